// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: RAW hazard detection, branch flush,
// SRAM wait-state sequencing and saturating stall statistics.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_WAIT = 3,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       id_src1,
   input  logic [3:0]       id_src2,
   input  logic             id_use_src1,
   input  logic             id_two_src,
   input  logic [3:0]       exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [3:0]       mem_dest,
   input  logic             mem_wb_en,
   input  logic             mem_req,
   input  logic             exe_br_taken,
   input  logic             fwd_en,
   output logic             freeze_pc,
   output logic             freeze_if_id,
   output logic             freeze_back,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             mem_done,
   output logic [CNT_W-1:0] hazard_cnt,
   output logic [CNT_W-1:0] mem_stall_cnt
);

   localparam int unsigned WAIT_W = 4;

   generate
      if (MEM_WAIT < 1 || MEM_WAIT > 15) begin : g_bad_wait
         $error("pipe_hazard_ctrl: MEM_WAIT must be in 1..15");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wcnt_q, wcnt_d;
   logic [CNT_W-1:0]  hazard_cnt_q, hazard_cnt_d;
   logic [CNT_W-1:0]  mem_stall_cnt_q, mem_stall_cnt_d;

   logic m1, m2, n1, n2;
   logic hazard;
   logic mem_stall;
   logic mem_done_raw;
   logic hazard_taken;

   // RAW detection against EXE/MEM destinations; with forwarding only a load-use stalls
   always_comb begin
      m1 = id_use_src1 && (id_src1 == exe_dest);
      m2 = id_two_src  && (id_src2 == exe_dest);
      n1 = id_use_src1 && (id_src1 == mem_dest);
      n2 = id_two_src  && (id_src2 == mem_dest);
      if (fwd_en) begin
         hazard = exe_mem_r_en && (m1 || m2);
      end else begin
         hazard = (exe_wb_en && (m1 || m2)) || (mem_wb_en && (n1 || n2));
      end
   end

   // SRAM wait-state sequencer; the IDLE-cycle request already stalls
   always_comb begin
      state_d      = state_q;
      wcnt_d       = wcnt_q;
      mem_stall    = 1'b0;
      mem_done_raw = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_req) begin
               mem_stall = 1'b1;
               wcnt_d    = WAIT_W'(MEM_WAIT - 1);
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            mem_stall = 1'b1;
            if (wcnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               wcnt_d = wcnt_q - WAIT_W'(1);
            end
         end
         ST_DONE: begin
            mem_done_raw = 1'b1;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
         end
      endcase
   end

   // Priority: memory stall, then branch flush, then hazard bubble
   always_comb begin
      freeze_pc    = 1'b0;
      freeze_if_id = 1'b0;
      freeze_back  = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      mem_done     = 1'b0;
      hazard_taken = 1'b0;
      if (!rst) begin
         mem_done = mem_done_raw;
         if (mem_stall) begin
            freeze_pc    = 1'b1;
            freeze_if_id = 1'b1;
            freeze_back  = 1'b1;
         end else if (exe_br_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
         end else if (hazard) begin
            freeze_pc    = 1'b1;
            freeze_if_id = 1'b1;
            flush_id_ex  = 1'b1;
            hazard_taken = 1'b1;
         end
      end
   end

   // Saturating statistics
   always_comb begin
      hazard_cnt_d    = hazard_cnt_q;
      mem_stall_cnt_d = mem_stall_cnt_q;
      if (hazard_taken && (hazard_cnt_q != '1)) begin
         hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
      end
      if (mem_stall && (mem_stall_cnt_q != '1)) begin
         mem_stall_cnt_d = mem_stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         wcnt_q          <= '0;
         hazard_cnt_q    <= '0;
         mem_stall_cnt_q <= '0;
      end else begin
         state_q         <= state_d;
         wcnt_q          <= wcnt_d;
         hazard_cnt_q    <= hazard_cnt_d;
         mem_stall_cnt_q <= mem_stall_cnt_d;
      end
   end

   assign hazard_cnt    = hazard_cnt_q;
   assign mem_stall_cnt = mem_stall_cnt_q;

   // A register is never frozen and flushed in the same cycle
   a_if_id_excl: assert property (@(posedge clk) !(freeze_if_id && flush_if_id));
   a_id_ex_excl: assert property (@(posedge clk) !(freeze_back && flush_id_ex));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default instance plus a CNT_W=4 / MEM_WAIT=1 instance.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
   logic       id_use_src1, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
   logic       mem_req, mem_req4, exe_br_taken, fwd_en;

   logic        freeze_pc, freeze_if_id, freeze_back, flush_if_id, flush_id_ex, mem_done;
   logic [15:0] hazard_cnt, mem_stall_cnt;
   logic        f_pc4, f_ifid4, f_back4, fl_ifid4, fl_idex4, done4;
   logic [3:0]  hazard_cnt4, mem_stall_cnt4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MEM_WAIT(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1), .id_two_src(id_two_src),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req),
      .exe_br_taken(exe_br_taken), .fwd_en(fwd_en),
      .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .freeze_back(freeze_back),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .mem_done(mem_done),
      .hazard_cnt(hazard_cnt), .mem_stall_cnt(mem_stall_cnt)
   );

   pipe_hazard_ctrl #(.MEM_WAIT(1), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1), .id_two_src(id_two_src),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req4),
      .exe_br_taken(exe_br_taken), .fwd_en(fwd_en),
      .freeze_pc(f_pc4), .freeze_if_id(f_ifid4), .freeze_back(f_back4),
      .flush_if_id(fl_ifid4), .flush_id_ex(fl_idex4), .mem_done(done4),
      .hazard_cnt(hazard_cnt4), .mem_stall_cnt(mem_stall_cnt4)
   );

   // {freeze_pc, freeze_if_id, freeze_back, flush_if_id, flush_id_ex, mem_done}
   localparam logic [5:0] O_NONE   = 6'b000000;
   localparam logic [5:0] O_HAZ    = 6'b110010;
   localparam logic [5:0] O_BR     = 6'b000110;
   localparam logic [5:0] O_STALL  = 6'b111000;
   localparam logic [5:0] O_DONE   = 6'b000001;

   function automatic logic [5:0] outs();
      return {freeze_pc, freeze_if_id, freeze_back, flush_if_id, flush_id_ex, mem_done};
   endfunction

   function automatic logic [5:0] outs4();
      return {f_pc4, f_ifid4, f_back4, fl_ifid4, fl_idex4, done4};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Start a new cycle: inputs change just after negedge, checks follow 1 time unit later
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      id_src1 = 4'd0; id_src2 = 4'd0; id_use_src1 = 1'b0; id_two_src = 1'b0;
      exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
      mem_dest = 4'd0; mem_wb_en = 1'b0; mem_req = 1'b0; mem_req4 = 1'b0;
      exe_br_taken = 1'b0; fwd_en = 1'b0;
   endtask

   task automatic exe_hazard_stim();
      id_src1 = 4'd3; id_use_src1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      next_cycle();
      // outputs forced low during reset even with active requests
      exe_hazard_stim(); exe_br_taken = 1'b1; mem_req = 1'b1;
      #1 check_eq("rst_outs", 32'(outs()), 32'(O_NONE));
      next_cycle();
      #1 check_eq("rst_hcnt", 32'(hazard_cnt), 32'd0);
      check_eq("rst_scnt", 32'(mem_stall_cnt), 32'd0);
      rst = 1'b0; clear_inputs();

      // no-forwarding EXE hazard on src1
      next_cycle(); exe_hazard_stim();
      #1 check_eq("haz_exe", 32'(outs()), 32'(O_HAZ));
      next_cycle(); clear_inputs();
      #1 check_eq("haz_clear", 32'(outs()), 32'(O_NONE));
      check_eq("haz_cnt1", 32'(hazard_cnt), 32'd1);

      // no-forwarding MEM hazard on src2, then with mem_wb_en low
      next_cycle(); id_two_src = 1'b1; id_src2 = 4'd7; mem_dest = 4'd7; mem_wb_en = 1'b1;
      #1 check_eq("haz_mem_src2", 32'(outs()), 32'(O_HAZ));
      next_cycle(); mem_wb_en = 1'b0;
      #1 check_eq("no_haz_mem_wb0", 32'(outs()), 32'(O_NONE));
      check_eq("haz_cnt2", 32'(hazard_cnt), 32'd2);

      // forwarding: only load-use stalls, once
      next_cycle(); clear_inputs(); fwd_en = 1'b1; exe_hazard_stim();
      #1 check_eq("fwd_no_load", 32'(outs()), 32'(O_NONE));
      next_cycle(); exe_mem_r_en = 1'b1;
      #1 check_eq("fwd_load_use", 32'(outs()), 32'(O_HAZ));
      next_cycle(); exe_mem_r_en = 1'b0; exe_wb_en = 1'b0; exe_dest = 4'd9;
      mem_dest = 4'd3; mem_wb_en = 1'b1;
      #1 check_eq("fwd_load_in_mem", 32'(outs()), 32'(O_NONE));
      check_eq("haz_cnt3", 32'(hazard_cnt), 32'd3);

      // branch overrides hazard and is not counted
      next_cycle(); clear_inputs(); exe_hazard_stim(); exe_br_taken = 1'b1;
      #1 check_eq("br_over_haz", 32'(outs()), 32'(O_BR));
      next_cycle(); clear_inputs();
      #1 check_eq("br_hcnt", 32'(hazard_cnt), 32'd3);

      // memory access, request held through DONE; hazard+branch in WAIT ignored
      for (int c = 0; c < 5; c++) begin
         next_cycle(); clear_inputs(); mem_req = 1'b1;
         if (c == 2) begin exe_hazard_stim(); exe_br_taken = 1'b1; end
         #1 check_eq($sformatf("mem_c%0d", c), 32'(outs()), 32'((c < 4) ? O_STALL : O_DONE));
      end
      next_cycle(); clear_inputs();
      #1 check_eq("mem_idle", 32'(outs()), 32'(O_NONE));
      check_eq("mem_scnt4", 32'(mem_stall_cnt), 32'd4);
      check_eq("mem_hcnt", 32'(hazard_cnt), 32'd3);

      // request dropping during WAIT does not abort the access
      for (int c = 0; c < 5; c++) begin
         next_cycle(); clear_inputs(); mem_req = (c == 0);
         #1 check_eq($sformatf("drop_c%0d", c), 32'(outs()), 32'((c < 4) ? O_STALL : O_DONE));
      end
      next_cycle(); clear_inputs();
      #1 check_eq("drop_scnt8", 32'(mem_stall_cnt), 32'd8);

      // reset in the second WAIT cycle aborts the access
      next_cycle(); mem_req = 1'b1;
      #1 check_eq("ra_c0", 32'(outs()), 32'(O_STALL));
      next_cycle();
      #1 check_eq("ra_c1", 32'(outs()), 32'(O_STALL));
      next_cycle(); rst = 1'b1;
      #1 check_eq("ra_rst", 32'(outs()), 32'(O_NONE));
      next_cycle(); rst = 1'b0; mem_req = 1'b0;
      #1 check_eq("ra_idle", 32'(outs()), 32'(O_NONE));
      check_eq("ra_scnt0", 32'(mem_stall_cnt), 32'd0);
      next_cycle();
      #1 check_eq("ra_no_done", 32'(outs()), 32'(O_NONE));
      for (int c = 0; c < 5; c++) begin
         next_cycle(); mem_req = (c < 5);
         #1 check_eq($sformatf("fresh_c%0d", c), 32'(outs()), 32'((c < 4) ? O_STALL : O_DONE));
      end
      next_cycle(); mem_req = 1'b0;
      #1 check_eq("fresh_scnt4", 32'(mem_stall_cnt), 32'd4);

      // MEM_WAIT=1 instance: two stall cycles, done in the third
      for (int c = 0; c < 3; c++) begin
         next_cycle(); mem_req4 = 1'b1;
         #1 check_eq($sformatf("w1_c%0d", c), 32'(outs4()), 32'((c < 2) ? O_STALL : O_DONE));
      end
      next_cycle(); mem_req4 = 1'b0;
      #1 check_eq("w1_idle", 32'(outs4()), 32'(O_NONE));
      check_eq("w1_scnt2", 32'(mem_stall_cnt4), 32'd2);

      // saturation: 20 hazard cycles on both instances
      next_cycle(); rst = 1'b1;
      next_cycle(); rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         next_cycle(); exe_hazard_stim();
         if (c == 16) #1 check_eq("sat_c16", 32'(hazard_cnt4), 32'd15);
      end
      next_cycle(); clear_inputs();
      #1 check_eq("sat_hcnt4", 32'(hazard_cnt4), 32'd15);
      check_eq("sat_hcnt16", 32'(hazard_cnt), 32'd20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
